// File: rtl/mmio_responder.sv
// -----------------------------------------------------------------------------
// mmio_responder
//
// Memory-mapped I/O responder that sits on the CPU data-memory bus next to the
// data RAM. It decodes a 256-byte window at BASE_ADDR and provides:
//   0x00 LED    (RW) 8-bit LED register, upper bits read 0
//   0x04 CYCLE  (RO) free-running cycle counter, any write clears it
//   0x08 TCMP   (RW) timer compare value            [MMIO_TIMER_EN only]
//   0x0C TCTRL  (RW) bit0 EN, bit1 AUTO             [MMIO_TIMER_EN only]
//   0x10 TCNT   (RW) timer count                    [MMIO_TIMER_EN only]
//   0x14 STATUS (W1C) bit0 MATCH                    [MMIO_TIMER_EN only]
// Read data is registered. It is forced to zero on a miss or when there is no
// read, so the system level can OR it with the RAM read data.
//
// Build option: define MMIO_TIMER_EN to include the compare timer. Without it,
// offsets 0x08-0x14 behave as unmapped and irq is tied to 0.
//
// Ports:
//   clk      - single clock, rising edge
//   reset    - asynchronous active-low reset
//   read_en  - read strobe, one cycle per access
//   write_en - write strobe, one cycle per access
//   address  - byte address, bits [1:0] ignored
//   data_in  - write data
//   data_out - registered read data (0 outside the window / when not reading)
//   led      - LED register contents
//   irq      - level interrupt, equal to STATUS.MATCH
// -----------------------------------------------------------------------------
module mmio_responder #(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_FF00,
    parameter logic [7:0]  LED_RESET = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        read_en,
    input  logic        write_en,
    input  logic [31:0] address,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic [7:0]  led,
    output logic        irq
);

    localparam logic [5:0] OFF_LED    = 6'h00;
    localparam logic [5:0] OFF_CYCLE  = 6'h01;
`ifdef MMIO_TIMER_EN
    localparam logic [5:0] OFF_TCMP   = 6'h02;
    localparam logic [5:0] OFF_TCTRL  = 6'h03;
    localparam logic [5:0] OFF_TCNT   = 6'h04;
    localparam logic [5:0] OFF_STATUS = 6'h05;
`endif

    logic       hit;
    logic [5:0] offset;
    logic       wr;
    logic       rd;

    assign hit    = (address[31:8] == BASE_ADDR[31:8]);
    assign offset = address[7:2];
    assign wr     = write_en & hit;
    assign rd     = read_en & hit;

    // Byte-lane bits and (without the timer) the upper write-data bits carry
    // no meaning for this block.
    logic unused_bits;
    assign unused_bits = ^{address[1:0], data_in};

    // ---------------------------------------------------------------- LED/CYCLE
    logic [7:0]  led_q, led_d;
    logic [31:0] cycle_q, cycle_d;

    always_comb begin
        led_d   = led_q;
        cycle_d = cycle_q + 32'd1;
        if (wr && offset == OFF_LED) begin
            led_d = data_in[7:0];
        end
        if (wr && offset == OFF_CYCLE) begin
            cycle_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            led_q   <= LED_RESET;
            cycle_q <= '0;
        end else begin
            led_q   <= led_d;
            cycle_q <= cycle_d;
        end
    end

    assign led = led_q;

    // -------------------------------------------------------------------- timer
`ifdef MMIO_TIMER_EN
    typedef enum logic {
        T_IDLE = 1'b0,
        T_RUN  = 1'b1
    } tstate_e;

    tstate_e     state_q, state_d;
    logic        auto_q, auto_d;
    logic [31:0] tcmp_q, tcmp_d;
    logic [31:0] tcnt_q, tcnt_d;
    logic        match_q, match_d;
    logic        hw_match;

    assign hw_match = (state_q == T_RUN) && (tcnt_q == tcmp_q);

    // Hardware update is computed first; software writes are applied after so
    // they override it. MATCH set is applied last so it beats a W1C.
    always_comb begin
        state_d = state_q;
        auto_d  = auto_q;
        tcmp_d  = tcmp_q;
        tcnt_d  = tcnt_q;
        match_d = match_q;

        if (state_q == T_RUN) begin
            if (hw_match) begin
                if (auto_q) begin
                    tcnt_d = '0;
                end else begin
                    state_d = T_IDLE;
                end
            end else begin
                tcnt_d = tcnt_q + 32'd1;
            end
        end

        if (wr) begin
            case (offset)
                OFF_TCMP:   tcmp_d = data_in;
                OFF_TCNT:   tcnt_d = data_in;
                OFF_TCTRL: begin
                    state_d = data_in[0] ? T_RUN : T_IDLE;
                    auto_d  = data_in[1];
                end
                OFF_STATUS: begin
                    if (data_in[0]) begin
                        match_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end

        if (hw_match) begin
            match_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= T_IDLE;
            auto_q  <= 1'b0;
            tcmp_q  <= '0;
            tcnt_q  <= '0;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            auto_q  <= auto_d;
            tcmp_q  <= tcmp_d;
            tcnt_q  <= tcnt_d;
            match_q <= match_d;
        end
    end

    assign irq = match_q;
`else
    assign irq = 1'b0;
`endif

    // ---------------------------------------------------------------- read path
    logic [31:0] rdata;
    logic [31:0] data_out_q, data_out_d;

    // Mux uses current register values, so a same-cycle write returns the
    // pre-write contents.
    always_comb begin
        rdata = '0;
        case (offset)
            OFF_LED:    rdata = {24'h0, led_q};
            OFF_CYCLE:  rdata = cycle_q;
`ifdef MMIO_TIMER_EN
            OFF_TCMP:   rdata = tcmp_q;
            OFF_TCTRL:  rdata = {30'h0, auto_q, (state_q == T_RUN)};
            OFF_TCNT:   rdata = tcnt_q;
            OFF_STATUS: rdata = {31'h0, match_q};
`endif
            default:    rdata = '0;
        endcase
        data_out_d = rd ? rdata : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_out_q <= '0;
        end else begin
            data_out_q <= data_out_d;
        end
    end

    assign data_out = data_out_q;

endmodule
